// File: rtl/alu_regfile_pkg.sv
// rtl/alu_regfile_pkg.sv - shared defaults and opcode constants for alu_regfile (optional logic ops: ALU_LOGIC_OPS_EN)
package alu_regfile_pkg;

   // Default geometry of the register file and data path
   localparam int DATA_W_DEF    = 16;
   localparam int REG_COUNT_DEF = 8;

   // ALU opcodes; every code not listed here produces a zero result
   localparam logic [3:0] OP_PASSB = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_OR    = 4'b0101;
   localparam logic [3:0] OP_XOR   = 4'b0110;
   localparam logic [3:0] OP_NOT   = 4'b0111;

endpackage

// File: rtl/alu_regfile_rf.sv
// rtl/alu_regfile_rf.sv - register array with one write port and two combinational read ports
module alu_regfile_rf #(
   parameter int DATA_W    = 16,
   parameter int REG_COUNT = 8,
   parameter int ADDR_W    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs [REG_COUNT];

   // Registers clear asynchronously; a write lands on the rising edge with no read bypass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Both read ports see the stored value directly, so equal addresses give equal data
   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file with combinational ALU on its two read ports (optional logic ops: ALU_LOGIC_OPS_EN)
module alu_regfile
   import alu_regfile_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int REG_COUNT = REG_COUNT_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [3:0]                   opcode,
   input  logic [$clog2(REG_COUNT)-1:0] address_a,
   input  logic [$clog2(REG_COUNT)-1:0] address_b,
   input  logic                         write_enable,
   input  logic [DATA_W-1:0]            write_data,
   output logic [DATA_W-1:0]            data_a,
   output logic [DATA_W-1:0]            data_b,
   output logic [DATA_W-1:0]            alu_result,
   output logic                         zero
);

   localparam int ADDR_W = $clog2(REG_COUNT);

   // address_a doubles as the write address
   alu_regfile_rf #(
      .DATA_W    (DATA_W),
      .REG_COUNT (REG_COUNT),
      .ADDR_W    (ADDR_W)
   ) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (write_enable),
      .waddr   (address_a),
      .wdata   (write_data),
      .raddr_a (address_a),
      .raddr_b (address_b),
      .rdata_a (data_a),
      .rdata_b (data_b)
   );

   // Combinational ALU; arithmetic wraps at DATA_W bits, unlisted opcodes yield zero
   always_comb begin
      alu_result = '0;
      case (opcode)
         OP_PASSB: alu_result = data_b;
         OP_ADD:   alu_result = data_a + data_b;
         OP_SUB:   alu_result = data_a - data_b;
`ifdef ALU_LOGIC_OPS_EN
         OP_AND:   alu_result = data_a & data_b;
         OP_OR:    alu_result = data_a | data_b;
         OP_XOR:   alu_result = data_a ^ data_b;
         OP_NOT:   alu_result = ~data_a;
`endif
         default:  alu_result = '0;
      endcase
   end

   // Zero flag tracks the result for every opcode, including the zero-result ones
   assign zero = (alu_result == '0);

endmodule

// File: tb/tb_alu_regfile.sv
// tb/tb_alu_regfile.sv - self-checking bench for alu_regfile (vector table plus corner sequences)
module tb_alu_regfile;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  opcode = 4'b0000;
   logic [2:0]  address_a = 3'd0;
   logic [2:0]  address_b = 3'd0;
   logic        write_enable = 1'b0;
   logic [15:0] write_data = 16'h0000;
   logic [15:0] data_a;
   logic [15:0] data_b;
   logic [15:0] alu_result;
   logic        zero;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] da;
      logic [15:0] db;
      logic        zr;
      logic [15:0] res;
   } exp_t;

   exp_t exp_q[$];

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic [3:0]  op;
      logic        same;
      logic [15:0] exp_res;
      logic        exp_zero;
   } vec_t;

   vec_t vecs[$];

   alu_regfile dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .address_a    (address_a),
      .address_b    (address_b),
      .write_enable (write_enable),
      .write_data   (write_data),
      .data_a       (data_a),
      .data_b       (data_b),
      .alu_result   (alu_result),
      .zero         (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [15:0] da, input logic [15:0] db,
                           input logic [15:0] res, input logic zr);
      exp_t e;
      e.da = da; e.db = db; e.res = res; e.zr = zr;
      exp_q.push_back(e);
   endtask

   task automatic sample(input string name);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %h expected entry", name, alu_result);
      end else begin
         e = exp_q.pop_front();
         check({name, ".data_a"}, data_a, e.da);
         check({name, ".data_b"}, data_b, e.db);
         check({name, ".alu_result"}, alu_result, e.res);
         check({name, ".zero"}, {15'd0, zero}, {15'd0, e.zr});
      end
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      address_a = a;
      write_data = d;
      write_enable = 1'b1;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
   endtask

   initial begin
      // vector table
      vecs.push_back('{16'h0005, 16'h0003, 4'b0010, 1'b0, 16'h0008, 1'b0});
      vecs.push_back('{16'h0005, 16'h0003, 4'b0011, 1'b0, 16'h0002, 1'b0});
      vecs.push_back('{16'hFFFF, 16'h0001, 4'b0010, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h0000, 16'h0001, 4'b0011, 1'b0, 16'hFFFF, 1'b0});
      vecs.push_back('{16'h1234, 16'h0000, 4'b0011, 1'b1, 16'h0000, 1'b1});
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b0001, 1'b0, 16'h0F0F, 1'b0});
`ifdef ALU_LOGIC_OPS_EN
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b0100, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b0101, 1'b0, 16'h0FFF, 1'b0});
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b0110, 1'b0, 16'h0FFF, 1'b0});
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b0111, 1'b0, 16'hFF0F, 1'b0});
`else
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b0100, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b0101, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b0110, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b0111, 1'b0, 16'h0000, 1'b1});
`endif
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b1111, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b0000, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b1000, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h00F0, 16'h0F0F, 4'b1100, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h7FFF, 16'h7FFF, 4'b0010, 1'b0, 16'hFFFE, 1'b0});

      // reset state, with a write attempted across an edge during reset
      #2 rst_n = 1'b0;
      address_a = 3'd4;
      write_data = 16'hBEEF;
      write_enable = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      write_enable = 1'b0;
      address_b = 3'd5;
      opcode = 4'b0010;
      push_exp(16'h0000, 16'h0000, 16'h0000, 1'b1);
      #1 sample("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      // first write after reset release
      write_reg(3'd6, 16'hA5A5);
      @(negedge clk);
      address_a = 3'd6;
      address_b = 3'd4;
      opcode = 4'b0001;
      push_exp(16'hA5A5, 16'h0000, 16'h0000, 1'b1);
      #1 sample("first_write");

      // table-driven vectors
      foreach (vecs[i]) begin
         write_reg(3'd1, vecs[i].va);
         if (!vecs[i].same) write_reg(3'd2, vecs[i].vb);
         @(negedge clk);
         address_a = 3'd1;
         address_b = vecs[i].same ? 3'd1 : 3'd2;
         opcode = vecs[i].op;
         push_exp(vecs[i].va, vecs[i].same ? vecs[i].va : vecs[i].vb,
                  vecs[i].exp_res, vecs[i].exp_zero);
         #1 sample($sformatf("vec%0d", i));
      end

      // read-during-write on r3
      write_reg(3'd3, 16'h00AA);
      @(negedge clk);
      address_a = 3'd3;
      address_b = 3'd3;
      opcode = 4'b0001;
      write_data = 16'h0055;
      write_enable = 1'b1;
      push_exp(16'h00AA, 16'h00AA, 16'h00AA, 1'b0);
      #1 sample("rdw_before");
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      push_exp(16'h0055, 16'h0055, 16'h0055, 1'b0);
      sample("rdw_after");
      @(negedge clk);
      write_data = 16'h1234;
      @(posedge clk);
      #1;
      push_exp(16'h0055, 16'h0055, 16'h0055, 1'b0);
      sample("we_low_hold");

      // asynchronous reset mid-run, away from any clock edge
      for (int r = 0; r < 8; r++) write_reg(r[2:0], 16'h1000 + 16'(r) + 16'h0001);
      @(negedge clk);
      address_a = 3'd7;
      check("pre_reset_r7", data_a, 16'h1008);
      #2 rst_n = 1'b0;
      for (int r = 0; r < 8; r++) begin
         address_a = r[2:0];
         address_b = 3'(7 - r);
         #0.5;
         check($sformatf("async_rst_a%0d", r), data_a, 16'h0000);
         check($sformatf("async_rst_b%0d", r), data_b, 16'h0000);
      end
      @(negedge clk);
      rst_n = 1'b1;

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_regfile.md
ALU_REGFILE -- requirements
Module: alu_regfile

Interface
REQ-001 Parameter DATA_W, default 16, data path width.
REQ-002 Parameter REG_COUNT, default 8, number of registers (address width 3).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active-low.
REQ-005 opcode  in  4  ALU operation select.
REQ-006 address_a  in  3  read port A address; also the write address.
REQ-007 address_b  in  3  read port B address.
REQ-008 write_enable  in  1  write strobe for register address_a.
REQ-009 write_data  in  DATA_W  data written when write_enable=1.
REQ-010 data_a  out  DATA_W  contents of register address_a.
REQ-011 data_b  out  DATA_W  contents of register address_b.
REQ-012 alu_result  out  DATA_W  ALU output, operands data_a (A) and data_b (B).
REQ-013 zero  out  1  1 when alu_result==0.

Function
REQ-014 SHALL hold REG_COUNT registers of DATA_W bits; no hard-wired zero register.
REQ-015 data_a/data_b SHALL be combinational reads, zero-cycle latency from address change.
REQ-016 On rising clk with write_enable=1, SHALL write write_data to register address_a; write_enable=0 leaves all registers unchanged.
REQ-017 Read of register being written SHALL return the old value until after the edge; new value visible the same cycle the edge completes (no bypass).
REQ-018 address_a==address_b SHALL give identical data_a and data_b.
REQ-019 ALU SHALL be purely combinational; alu_result and zero valid in the same cycle as operands/opcode.
REQ-020 opcode 4'b0010 ADD: A+B modulo 2^DATA_W, carry discarded.
REQ-021 opcode 4'b0011 SUB: A-B modulo 2^DATA_W (two's complement wrap, 0-1=16'hFFFF).
REQ-022 opcode 4'b0001 PASSB: alu_result=B.
REQ-023 Opcodes 4'b0100..4'b0111 per Configuration; all other opcodes (incl. 0000, 1000, 1100, 1111): alu_result=0.
REQ-024 zero SHALL be derived from alu_result for every opcode (so zero=1 for result-0 opcodes).

Reset
REQ-025 rst_n=0 SHALL asynchronously clear all registers to 0; data_a/data_b read 0 immediately, alu_result/zero follow combinationally.
REQ-026 Writes SHALL be ignored while rst_n=0; first write takes effect on the first rising clk after rst_n deasserts.

Configuration
REQ-027 Macro ALU_LOGIC_OPS_EN defined: 0100 AND, 0101 OR, 0110 XOR, 0111 NOT A.
REQ-028 Macro undefined: opcodes 0100..0111 SHALL yield alu_result=0, zero=1; logic not synthesized.

Structure
REQ-029 Package alu_regfile_pkg SHALL hold DATA_W/REG_COUNT defaults and opcode constants (OP_PASSB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT).
REQ-030 Register array SHALL be one sub-module alu_regfile_rf; ALU logic inline in alu_regfile.

Verification
REQ-031 Reset: rst_n=0 mid-run after writes -> all data_a/data_b read 0 for every address without clock edge.
REQ-032 Write/read: write 16'h0005 to r1, 16'h0003 to r2; address_a=1,address_b=2 -> data_a=5,data_b=3; ADD ->8,zero=0; SUB ->2,zero=0.
REQ-033 Wrap: r1=16'hFFFF,r2=16'h0001 -> ADD=0,zero=1; r1=0,r2=1 SUB=16'hFFFF,zero=0; equal operands SUB ->0,zero=1.
REQ-034 Read-during-write: r3=16'h00AA, write 16'h0055 to r3 -> data_a=16'h00AA before edge, 16'h0055 after; write_enable=0 with new write_data -> r3 unchanged.
REQ-035 Opcodes: A=16'h00F0,B=16'h0F0F -> PASSB=16'h0F0F; with ALU_LOGIC_OPS_EN AND=16'h0000(zero=1),OR=16'h0FFF,XOR=16'h0FFF,NOT=16'hFF0F; without macro all four ->0; opcode 4'b1111 ->0,zero=1.
